// File: rtl/bfp16_pkg.sv
// bfp16_pkg
// Shared types and constants for the BFP16 adder datapath.
//   bfp16_t   : packed bfloat16 view {sign, exp[7:0], man[6:0]}
//   EXP_MAX   : all-ones exponent marking inf/NaN
//   EXP_BIAS  : exponent bias of the format
//   SIZE_GRS  : guard/round/sticky bits kept below the fraction
//   SIZE_AMAN : aligned mantissa width {hidden, fraction, GRS}
package bfp16_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bfp16_t;

  localparam logic [7:0] EXP_MAX   = 8'hFF;
  localparam logic [7:0] EXP_BIAS  = 8'd127;
  localparam int         SIZE_GRS  = 3;
  localparam int         SIZE_AMAN = 7 + 1 + SIZE_GRS;

endpackage

// File: rtl/bfp16_align_shifter.sv
// bfp16_align_shifter
// Combinational right shifter for mantissa alignment. Every bit shifted out
// below bit 0 is collapsed into a sticky bit that is ORed into the LSB, so
// the rounding logic downstream still sees that something nonzero was lost.
//   din   : unaligned mantissa
//   shamt : exponent difference (shift distance)
//   dout  : aligned mantissa with sticky in bit 0
module bfp16_align_shifter
  import bfp16_pkg::*;
#(
  parameter int WIDTH   = SIZE_AMAN,
  parameter int SHIFT_W = 8
) (
  input  logic [WIDTH-1:0]   din,
  input  logic [SHIFT_W-1:0] shamt,
  output logic [WIDTH-1:0]   dout
);

  localparam logic [SHIFT_W-1:0] WIDTH_S = SHIFT_W'(WIDTH);

  logic [WIDTH-1:0] lost_mask;
  logic             sticky;

  // Shifts of the full width or more leave only the sticky bit behind.
  always_comb begin
    lost_mask = '0;
    sticky    = 1'b0;
    dout      = din;
    if (shamt >= WIDTH_S) begin
      dout = {{(WIDTH-1){1'b0}}, |din};
    end else begin
      lost_mask = ~({WIDTH{1'b1}} << shamt);
      sticky    = |(din & lost_mask);
      dout      = (din >> shamt) | {{(WIDTH-1){1'b0}}, sticky};
    end
  end

endmodule

// File: rtl/bfp16_exp_align.sv
// bfp16_exp_align
// Front end of the BFP16 adder. Unpacks two bfloat16 operands, orders them
// by magnitude, and right-aligns the smaller mantissa to the larger exponent
// with guard/round/sticky bits. Two-stage valid/ready pipeline with full
// backpressure; latency 2, throughput 1 pair per cycle.
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   i_valid / o_ready   : operand pair handshake (o_ready is combinational)
//   i_data_a, i_data_b  : bfloat16 operands
//   o_valid / i_ready   : result handshake
//   o_sign_big          : sign of larger-magnitude operand
//   o_eff_sub           : operand signs differ
//   o_exp_big           : exponent of larger operand
//   o_man_big           : {hidden, fraction, GRS=0} of larger operand
//   o_man_small         : smaller mantissa aligned, sticky in LSB
//   o_zero_flag         : exact-zero sum (never set when o_special)
//   o_special           : an operand is inf/NaN
module bfp16_exp_align #(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 7,
  parameter int SIZE_GRS = 3
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [SIZE_EXP+SIZE_MAN:0]     i_data_a,
  input  logic [SIZE_EXP+SIZE_MAN:0]     i_data_b,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_sign_big,
  output logic                           o_eff_sub,
  output logic [SIZE_EXP-1:0]            o_exp_big,
  output logic [SIZE_MAN+SIZE_GRS:0]     o_man_big,
  output logic [SIZE_MAN+SIZE_GRS:0]     o_man_small,
  output logic                           o_zero_flag,
  output logic                           o_special
);

  localparam int SIZE_AMAN = SIZE_MAN + 1 + SIZE_GRS;
  localparam int SIZE_MAG  = SIZE_EXP + SIZE_MAN;

  import bfp16_pkg::*;

  logic                 s1_adv, s2_adv;
  logic                 sign_a, sign_b, zero_a, zero_b, a_big;
  logic                 eff_sub_in, special_in, zero_pre_in;
  logic [SIZE_EXP-1:0]  exp_a, exp_b, exp_big_in, exp_small_in, diff_in;
  logic [SIZE_MAG-1:0]  mag_a, mag_b;
  logic [SIZE_AMAN-1:0] aman_a, aman_b;

  logic                 s1_valid, s1_sign_big, s1_eff_sub, s1_special, s1_zero_pre;
  logic [SIZE_EXP-1:0]  s1_exp_big, s1_diff;
  logic [SIZE_AMAN-1:0] s1_man_big, s1_man_small;
  logic [SIZE_AMAN-1:0] man_small_aligned;

  assign s2_adv  = ~o_valid | i_ready;
  assign s1_adv  = ~s1_valid | s2_adv;
  assign o_ready = s1_adv;

  // Denormals (exp==0) are flushed to zero before the magnitude compare, so
  // a flushed operand has magnitude 0, exponent 0 and no hidden bit.
  always_comb begin
    sign_a       = i_data_a[SIZE_MAG];
    sign_b       = i_data_b[SIZE_MAG];
    exp_a        = i_data_a[SIZE_MAG-1:SIZE_MAN];
    exp_b        = i_data_b[SIZE_MAG-1:SIZE_MAN];
    zero_a       = (exp_a == '0);
    zero_b       = (exp_b == '0);
    mag_a        = zero_a ? '0 : i_data_a[SIZE_MAG-1:0];
    mag_b        = zero_b ? '0 : i_data_b[SIZE_MAG-1:0];
    aman_a       = zero_a ? '0 : {1'b1, i_data_a[SIZE_MAN-1:0], {SIZE_GRS{1'b0}}};
    aman_b       = zero_b ? '0 : {1'b1, i_data_b[SIZE_MAN-1:0], {SIZE_GRS{1'b0}}};
    a_big        = (mag_a >= mag_b);
    exp_big_in   = a_big ? exp_a : exp_b;
    exp_small_in = a_big ? exp_b : exp_a;
    diff_in      = exp_big_in - exp_small_in;
    eff_sub_in   = sign_a ^ sign_b;
    special_in   = (&exp_a) | (&exp_b);
    zero_pre_in  = (zero_a & zero_b) | (eff_sub_in & (mag_a == mag_b));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid     <= 1'b0;
      s1_sign_big  <= 1'b0;
      s1_eff_sub   <= 1'b0;
      s1_special   <= 1'b0;
      s1_zero_pre  <= 1'b0;
      s1_exp_big   <= '0;
      s1_diff      <= '0;
      s1_man_big   <= '0;
      s1_man_small <= '0;
    end else if (s1_adv) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_sign_big  <= a_big ? sign_a : sign_b;
        s1_eff_sub   <= eff_sub_in;
        s1_special   <= special_in;
        s1_zero_pre  <= zero_pre_in;
        s1_exp_big   <= exp_big_in;
        s1_diff      <= diff_in;
        s1_man_big   <= a_big ? aman_a : aman_b;
        s1_man_small <= a_big ? aman_b : aman_a;
      end
    end
  end

  bfp16_align_shifter #(
    .WIDTH   (SIZE_AMAN),
    .SHIFT_W (SIZE_EXP)
  ) u_shifter (
    .din   (s1_man_small),
    .shamt (s1_diff),
    .dout  (man_small_aligned)
  );

  // Inf/NaN results are resolved by the back end, so the zero shortcut is
  // suppressed whenever a special operand is present.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid     <= 1'b0;
      o_sign_big  <= 1'b0;
      o_eff_sub   <= 1'b0;
      o_exp_big   <= '0;
      o_man_big   <= '0;
      o_man_small <= '0;
      o_zero_flag <= 1'b0;
      o_special   <= 1'b0;
    end else if (s2_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_sign_big  <= s1_sign_big;
        o_eff_sub   <= s1_eff_sub;
        o_exp_big   <= s1_exp_big;
        o_man_big   <= s1_man_big;
        o_man_small <= man_small_aligned;
        o_zero_flag <= s1_zero_pre & ~s1_special;
        o_special   <= s1_special;
      end
    end
  end

endmodule

// File: tb/tb_bfp16_exp_align.sv
// tb_bfp16_exp_align
// Self-checking bench for bfp16_exp_align: directed vectors with literal
// expectations plus an arithmetic reference model feeding an in-order
// scoreboard that is compared on every cycle o_valid is high.
module tb_bfp16_exp_align;
  import bfp16_pkg::*;

  typedef struct packed {
    logic        sign_big;
    logic        eff_sub;
    logic [7:0]  exp_big;
    logic [10:0] man_big;
    logic [10:0] man_small;
    logic        zero_flag;
    logic        special;
  } result_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_data_a;
  logic [15:0] i_data_b;
  logic        o_valid;
  logic        i_ready;
  logic        o_sign_big;
  logic        o_eff_sub;
  logic [7:0]  o_exp_big;
  logic [10:0] o_man_big;
  logic [10:0] o_man_small;
  logic        o_zero_flag;
  logic        o_special;

  int      errors = 0;
  int      checks = 0;
  result_t exp_q[$];
  result_t sb_act;

  logic [15:0] stream_a [6] = '{16'h3F80, 16'h3F00, 16'h4B80, 16'h4180, 16'h4040, 16'hC2F5};
  logic [15:0] stream_b [6] = '{16'h3F00, 16'hBF80, 16'h3F81, 16'h3F81, 16'hC040, 16'h4228};

  always #5 i_clk = ~i_clk;

  bfp16_exp_align dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data_a    (i_data_a),
    .i_data_b    (i_data_b),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_sign_big  (o_sign_big),
    .o_eff_sub   (o_eff_sub),
    .o_exp_big   (o_exp_big),
    .o_man_big   (o_man_big),
    .o_man_small (o_man_small),
    .o_zero_flag (o_zero_flag),
    .o_special   (o_special)
  );

  // Reference: magnitudes and mantissas as plain integers; alignment is a
  // division by 2**diff with any nonzero remainder setting the LSB.
  function automatic result_t model(input bfp16_t a, input bfp16_t b);
    result_t r;
    int mag_a, mag_b, mant_a, mant_b, e_big, e_small, diff, raw, div, q;
    bit a_big;
    mag_a   = (a.exp == 8'd0) ? 0 : int'(a.exp) * 128 + int'(a.man);
    mag_b   = (b.exp == 8'd0) ? 0 : int'(b.exp) * 128 + int'(b.man);
    mant_a  = (a.exp == 8'd0) ? 0 : (128 + int'(a.man)) * 8;
    mant_b  = (b.exp == 8'd0) ? 0 : (128 + int'(b.man)) * 8;
    a_big   = (mag_a >= mag_b);
    e_big   = a_big ? int'(a.exp) : int'(b.exp);
    e_small = a_big ? int'(b.exp) : int'(a.exp);
    diff    = e_big - e_small;
    raw     = a_big ? mant_b : mant_a;
    if (diff >= 11) begin
      q = (raw != 0) ? 1 : 0;
    end else begin
      div = 1 << diff;
      q   = raw / div;
      if ((raw % div) != 0) q = q | 1;
    end
    r.sign_big  = a_big ? a.sign : b.sign;
    r.eff_sub   = a.sign ^ b.sign;
    r.exp_big   = 8'(e_big);
    r.man_big   = 11'(a_big ? mant_a : mant_b);
    r.man_small = 11'(q);
    r.special   = (a.exp == 8'hFF) || (b.exp == 8'hFF);
    r.zero_flag = !r.special && ((mag_a == 0 && mag_b == 0) || (r.eff_sub && mag_a == mag_b));
    return r;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // In-order scoreboard: compare head while o_valid, pop on consume, push on accept.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      exp_q.delete();
    end else begin
      if (o_valid) begin
        sb_act = {o_sign_big, o_eff_sub, o_exp_big, o_man_big, o_man_small, o_zero_flag, o_special};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL scoreboard_spurious: got o_valid=1 expected o_valid=0 (nothing outstanding)");
        end else if (sb_act !== exp_q[0]) begin
          errors++;
          $display("[TB] FAIL scoreboard: got %h expected %h", sb_act, exp_q[0]);
        end
        if (i_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (i_valid && o_ready) exp_q.push_back(model(i_data_a, i_data_b));
    end
  end

  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b);
    int waited;
    waited   = 0;
    i_data_a = a;
    i_data_b = b;
    i_valid  = 1'b1;
    while (!o_ready && waited < 20) begin
      @(posedge i_clk); #1;
      waited++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got o_ready=0 expected o_ready=1 within 20 cycles");
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic check_output(input string name, input logic sb, input logic es,
                              input logic [7:0] eb, input logic [10:0] mb,
                              input logic [10:0] ms, input logic zf, input logic sp);
    check_val({name, "_valid"},     32'(o_valid),     32'd1);
    check_val({name, "_sign_big"},  32'(o_sign_big),  32'(sb));
    check_val({name, "_eff_sub"},   32'(o_eff_sub),   32'(es));
    check_val({name, "_exp_big"},   32'(o_exp_big),   32'(eb));
    check_val({name, "_man_big"},   32'(o_man_big),   32'(mb));
    check_val({name, "_man_small"}, 32'(o_man_small), 32'(ms));
    check_val({name, "_zero"},      32'(o_zero_flag), 32'(zf));
    check_val({name, "_special"},   32'(o_special),   32'(sp));
  endtask

  task automatic run_directed(input string name, input logic [15:0] a, input logic [15:0] b,
                              input logic sb, input logic es, input logic [7:0] eb,
                              input logic [10:0] mb, input logic [10:0] ms,
                              input logic zf, input logic sp);
    apply_stimulus(a, b);
    @(posedge i_clk); #1;
    check_output(name, sb, es, eb, mb, ms, zf, sp);
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 30) begin
      @(posedge i_clk); #1;
      waited++;
    end
    check_val(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  k;
    int  idx;
    logic took;
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_data_a = '0;
    i_data_b = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check_val("reset_o_valid",     32'(o_valid),     32'd0);
    check_val("reset_exp_big",     32'(o_exp_big),   32'd0);
    check_val("reset_man_big",     32'(o_man_big),   32'd0);
    check_val("reset_man_small",   32'(o_man_small), 32'd0);
    check_val("reset_flags",       32'({o_sign_big, o_eff_sub, o_zero_flag, o_special}), 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check_val("idle_o_ready", 32'(o_ready), 32'd1);

    // Directed vectors: exact latency 2, swap, sticky-only, partial shift, zeros, specials.
    run_directed("t1_basic",   16'h3F80, 16'h3F00, 1'b0, 1'b0, 8'h7F, 11'h400, 11'h200, 1'b0, 1'b0);
    run_directed("t2_swap",    16'h3F00, 16'hBF80, 1'b1, 1'b1, 8'h7F, 11'h400, 11'h200, 1'b0, 1'b0);
    run_directed("t3_sticky",  16'h4B80, 16'h3F81, 1'b0, 1'b0, 8'h97, 11'h400, 11'h001, 1'b0, 1'b0);
    run_directed("t3_shift4",  16'h4180, 16'h3F81, 1'b0, 1'b0, 8'h83, 11'h400, 11'h041, 1'b0, 1'b0);
    run_directed("t4_cancel",  16'h4040, 16'hC040, 1'b0, 1'b1, 8'h80, 11'h600, 11'h600, 1'b1, 1'b0);
    run_directed("t4_zeros",   16'h0000, 16'h8000, 1'b0, 1'b1, 8'h00, 11'h000, 11'h000, 1'b1, 1'b0);
    run_directed("t4_flush",   16'h0001, 16'h0000, 1'b0, 1'b0, 8'h00, 11'h000, 11'h000, 1'b1, 1'b0);
    run_directed("t6_infinf",  16'h7F80, 16'hFF80, 1'b0, 1'b1, 8'hFF, 11'h400, 11'h400, 1'b0, 1'b1);
    run_directed("t6_infnum",  16'h7F80, 16'h3F80, 1'b0, 1'b0, 8'hFF, 11'h400, 11'h001, 1'b0, 1'b1);
    drain("drain_directed");

    // Back-to-back stream with downstream stalled in cycles 3-6.
    repeat (2) @(posedge i_clk);
    #1;
    idx = 0;
    k   = 0;
    while (idx < 6 && k < 40) begin
      k++;
      i_ready  = !(k >= 3 && k <= 6);
      i_valid  = 1'b1;
      i_data_a = stream_a[idx];
      i_data_b = stream_b[idx];
      @(negedge i_clk);
      if (k >= 3 && k <= 6) check_val($sformatf("stall_o_ready_c%0d", k), 32'(o_ready), 32'd0);
      took = o_ready;
      @(posedge i_clk); #1;
      if (took) idx++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    check_val("stream_accepted", 32'(idx), 32'd6);
    drain("drain_stream");

    // Reset with two pairs in flight: both must vanish.
    i_valid  = 1'b1;
    i_data_a = 16'h3F80;
    i_data_b = 16'h3F00;
    @(posedge i_clk); #1;
    i_data_a = 16'h4040;
    i_data_b = 16'h3F80;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    check_val("rst_flush_o_valid", 32'(o_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk); #1;
      check_val($sformatf("rst_gone_c%0d", c), 32'(o_valid), 32'd0);
    end

    run_directed("t7_recover", 16'h3F80, 16'h3F00, 1'b0, 1'b0, 8'h7F, 11'h400, 11'h200, 1'b0, 1'b0);
    drain("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
